// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Summary  : Shared constants and the buffered-fetch entry type for the
//            instruction fetch front end.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] INST_BYTES = 32'd4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam fetch_entry_t c_empty_entry = '{inst: NOP_INST, pc: 32'h0};

endpackage
`default_nettype wire

// File: rtl/fetch_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_fifo
// Summary  : Shift-style FIFO of fetch entries; entry 0 is always the head,
//            so the presented instruction comes straight from a register.
// Revision : 1.0
// ============================================================================
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           push_in,
    input  fetch_entry_t                   push_data_in,
    input  logic                           pop_in,
    input  logic                           flush_in,
    output fetch_entry_t                   head_out,
    output logic [$clog2(DEPTH+1)-1:0]     count_out,
    output logic                           empty_out,
    output logic                           full_out
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);

    fetch_entry_t        r_mem     [DEPTH];
    fetch_entry_t        w_mem_nxt [DEPTH];
    logic [c_cnt_w-1:0]  r_count;
    logic [c_cnt_w-1:0]  w_count_nxt;
    logic [c_cnt_w-1:0]  w_wr_idx;

    // Write slot sits just past the last live entry after any pop shift.
    always_comb begin
        w_wr_idx    = r_count - c_cnt_w'(pop_in);
        w_count_nxt = r_count + c_cnt_w'(push_in) - c_cnt_w'(pop_in);
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_mem_nxt[i] = pop_in ? r_mem[i+1] : r_mem[i];
        end
        w_mem_nxt[DEPTH-1] = pop_in ? c_empty_entry : r_mem[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (push_in && (w_wr_idx == c_cnt_w'(i))) begin
                w_mem_nxt[i] = push_data_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= c_empty_entry;
            end
        end else if (flush_in) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= c_empty_entry;
            end
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_mem_nxt[i];
            end
        end
    end

    assign head_out  = r_mem[0];
    assign count_out = r_count;
    assign empty_out = (r_count == '0);
    assign full_out  = (r_count == c_cnt_w'(DEPTH));

    a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !(push_in && !pop_in && !flush_in && full_out));

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Summary  : PC register, request tag pipeline and issue control feeding a
//            skid FIFO that presents instructions to the instruction queue.
// Revision : 1.0
// ============================================================================
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic        imem_en_out,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_data_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        valid_out,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    input  logic        ready_in
);

    localparam int c_depth = MEM_LATENCY + 1;
    localparam int c_cnt_w = $clog2(c_depth + 1);
    localparam logic [c_cnt_w:0] c_depth_lim = (c_cnt_w + 1)'(c_depth);

    logic [31:0]            r_pc;
    logic [MEM_LATENCY-1:0] r_tag_valid;
    logic [31:0]            r_tag_pc [MEM_LATENCY];
    logic [c_cnt_w-1:0]     r_inflight;

    logic [c_cnt_w-1:0]     w_fifo_count;
    fetch_entry_t           w_head;
    fetch_entry_t           w_push_data;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_issue;
    logic                   w_ret;
    logic [c_cnt_w:0]       w_occupancy;

    assign w_pop       = valid_out && ready_in;
    assign w_ret       = r_tag_valid[MEM_LATENCY-1];
    assign w_push      = w_ret && !redirect_in;
    assign w_push_data = '{inst: imem_data_in, pc: r_tag_pc[MEM_LATENCY-1]};

    // Requests in flight plus buffered words may never exceed the FIFO depth,
    // which is what guarantees every return has a free slot.
    assign w_occupancy = {1'b0, r_inflight} + {1'b0, w_fifo_count}
                         - (c_cnt_w + 1)'(w_pop);
    assign w_issue     = rst_n_in && !redirect_in && (w_occupancy < c_depth_lim);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pc <= RESET_PC;
        end else if (redirect_in) begin
            r_pc <= {redirect_pc_in[31:2], 2'b00};
        end else if (w_issue) begin
            r_pc <= r_pc + INST_BYTES;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tag_valid <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_tag_pc[i] <= '0;
            end
        end else begin
            r_tag_valid[0] <= w_issue;
            r_tag_pc[0]    <= r_pc;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_pc[i]    <= r_tag_pc[i-1];
            end
            if (redirect_in) begin
                r_tag_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_inflight <= '0;
        end else if (redirect_in) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= r_inflight + c_cnt_w'(w_issue) - c_cnt_w'(w_ret);
        end
    end

    fetch_skid_fifo #(
        .DEPTH (c_depth)
    ) u_fifo (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .push_in      (w_push),
        .push_data_in (w_push_data),
        .pop_in       (w_pop),
        .flush_in     (redirect_in),
        .head_out     (w_head),
        .count_out    (w_fifo_count),
        .empty_out    (w_empty),
        .full_out     (w_full)
    );

    assign imem_en_out     = w_issue;
    assign imem_addr_out   = r_pc;
    assign valid_out       = !w_empty;
    assign instruction_out = w_empty ? 32'h0 : w_head.inst;
    assign pc_out          = w_empty ? 32'h0 : w_head.pc;

    a_full_implies_idle: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        w_full |-> (r_inflight == '0));

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Summary  : Randomised bench for instruction_fetch with a queue-based model
//            of the expected fetch stream and a fixed-latency memory.
// Revision : 1.0
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          L        = 2;
    localparam int          DEPTH    = L + 1;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        imem_en_out;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_data_in = 32'h0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'h0;
    logic        valid_out;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        ready_in = 1'b0;

    always #5 clk_in = ~clk_in;

    instruction_fetch #(
        .RESET_PC    (RESET_PC),
        .MEM_LATENCY (L)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .imem_en_out     (imem_en_out),
        .imem_addr_out   (imem_addr_out),
        .imem_data_in    (imem_data_in),
        .redirect_in     (redirect_in),
        .redirect_pc_in  (redirect_pc_in),
        .valid_out       (valid_out),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .ready_in        (ready_in)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Every issued-but-not-yet-transferred fetch, oldest first.
    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } req_t;
    req_t        q[$];
    logic [31:0] nxt_pc = RESET_PC;

    logic        mp_v [L];
    logic [31:0] mp_a [L];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        nxt_pc = RESET_PC;
    endtask

    task automatic cycle(input logic rst, input logic rdy, input logic rd, input logic [31:0] rpc);
        bit   exp_v;
        bit   pop;
        bit   exp_en;
        req_t r;
        @(posedge clk_in);
        #1;
        rst_n_in       = rst;
        ready_in       = rdy;
        redirect_in    = rd;
        redirect_pc_in = rpc;
        imem_data_in   = mp_v[L-1] ? mem_word(mp_a[L-1]) : $urandom;
        @(negedge clk_in);
        for (int k = L - 1; k > 0; k--) begin
            mp_v[k] = mp_v[k-1];
            mp_a[k] = mp_a[k-1];
        end
        mp_v[0] = imem_en_out;
        mp_a[0] = imem_addr_out;
        if (!rst) begin
            chk("reset_valid_out", valid_out, 0);
            chk("reset_imem_en", imem_en_out, 0);
            model_reset();
        end else begin
            exp_v = (q.size() > 0) && (cyc >= q[0].cyc + L + 1);
            chk("valid_out", valid_out, exp_v);
            if (exp_v) begin
                chk("pc_out", pc_out, q[0].pc);
                chk("instruction_out", instruction_out, mem_word(q[0].pc));
            end
            pop    = exp_v && rdy;
            exp_en = !rd && ((q.size() - int'(pop)) < DEPTH);
            chk("imem_en_out", imem_en_out, exp_en);
            if (exp_en) chk("imem_addr_out", imem_addr_out, nxt_pc);
            if (pop) void'(q.pop_front());
            if (rd) begin
                q.delete();
                nxt_pc = {rpc[31:2], 2'b00};
            end else if (exp_en) begin
                r.pc  = nxt_pc;
                r.cyc = cyc;
                q.push_back(r);
                nxt_pc = nxt_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic async_reset();
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b0;
        #1;
        chk("async_valid_out", valid_out, 0);
        chk("async_imem_en", imem_en_out, 0);
        chk("async_instruction", instruction_out, 0);
        chk("async_pc_out", pc_out, 0);
        chk("async_imem_addr", imem_addr_out, RESET_PC);
        model_reset();
    endtask

    initial begin
        int first;
        int en_cnt;
        int bias;
        for (int k = 0; k < L; k++) begin
            mp_v[k] = 1'b0;
            mp_a[k] = 32'h0;
        end

        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_instruction", instruction_out, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_imem_addr", imem_addr_out, RESET_PC);

        // Start-up stream: first transfer three cycles after release.
        first = -1;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (valid_out && first < 0) first = k;
            if (k >= 3 && k <= 6) chk("startup_pc", pc_out, RESET_PC + 32'(4 * (k - 3)));
        end
        chk("first_valid_cycle", first, 3);

        // Back-pressure for ten cycles, then resume.
        en_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            if (imem_en_out) en_cnt++;
            chk("stall_pc", pc_out, 32'h124);
            chk("stall_inst", instruction_out, mem_word(32'h124));
        end
        chk("stall_issue_count", en_cnt, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            chk("resume_pc", pc_out, 32'h124 + 32'(4 * k));
        end

        // Redirect coinciding with a pop and a return.
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_2002);
        chk("redir_pop_pc", pc_out, 32'h13C);
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (k == 1) begin
                chk("redir_issue_en", imem_en_out, 1);
                chk("redir_issue_addr", imem_addr_out, 32'h2000);
            end
            if (k <= 3) chk("redir_bubble", valid_out, 0);
            if (k == 4) chk("redir_first_pc", pc_out, 32'h2000);
            if (k == 5) chk("redir_second_pc", pc_out, 32'h2004);
        end

        // Address wrap at the top of the space.
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (k >= 4) chk("wrap_pc", pc_out, 32'hFFFF_FFF8 + 32'(4 * (k - 4)));
        end

        // Randomised traffic with shifting ready bias and sporadic events.
        bias = 100;
        for (int n = 0; n < 2500; n++) begin
            if (n % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0: bias = 100;
                    1: bias = 70;
                    2: bias = 30;
                    default: bias = 0;
                endcase
            end
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
                cycle(1'b0, 1'b1, 1'b0, 32'h0);
            end else begin
                cycle(1'b1,
                      $urandom_range(0, 99) < bias,
                      $urandom_range(0, 29) == 0,
                      ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom);
            end
        end

        // Reset asserted between edges in the middle of a stream.
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        async_reset();
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (k == 0) begin
                chk("restart_en", imem_en_out, 1);
                chk("restart_addr", imem_addr_out, RESET_PC);
            end
            if (k == 3) chk("restart_pc", pc_out, RESET_PC);
            if (k == 4) chk("restart_pc_next", pc_out, RESET_PC + 32'd4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
